// File: rtl/huc6261_pkg.sv
// rtl/huc6261_pkg.sv - shared types and widths for the HuC6261 palette-port scheduler
package huc6261_pkg;

  localparam int CP_ADDR_W = 9;
  localparam int CP_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_RD_ISSUE = 2'd2,
    ST_RD_WAIT  = 2'd3
  } cp_sched_state_t;

  typedef struct packed {
    logic [CP_ADDR_W-1:0] addr;
    logic [CP_DATA_W-1:0] data;
  } cp_wr_entry_t;

endpackage

// File: rtl/cp_wr_fifo.sv
// rtl/cp_wr_fifo.sv - clock-enabled synchronous FIFO buffering palette writes
module cp_wr_fifo
  import huc6261_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         resn_i,
  input  logic                         ce_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  cp_wr_entry_t                 din_i,
  output cp_wr_entry_t                 dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  cp_wr_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (ce_i && do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk_i) begin
    if (!resn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (ce_i) begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/huc6261_cp_sched.sv
// rtl/huc6261_cp_sched.sv - palette-RAM port A scheduler committing CPU accesses only in blanking
module huc6261_cp_sched
  import huc6261_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CP_ADDR_W  = huc6261_pkg::CP_ADDR_W,
  parameter int CP_DATA_W  = huc6261_pkg::CP_DATA_W
) (
  input  logic                 CLK,
  input  logic                 RESn,
  input  logic                 CE,
  input  logic                 SET_ADDR,
  input  logic [CP_ADDR_W-1:0] ADDR_IN,
  input  logic                 WR_REQ,
  input  logic [CP_DATA_W-1:0] DATA_IN,
  input  logic                 RD_REQ,
  input  logic                 HBL,
  input  logic                 VBL,
  input  logic                 FORCE,
  output logic [CP_ADDR_W-1:0] PTR,
  output logic                 FULL,
  output logic                 BUSY,
  output logic                 OVF,
  output logic [CP_DATA_W-1:0] RD_DATA,
  output logic                 RD_VALID,
  output logic [CP_ADDR_W-1:0] RAM_ADDR,
  output logic [CP_DATA_W-1:0] RAM_DIN,
  output logic                 RAM_WE,
  input  logic [CP_DATA_W-1:0] RAM_Q
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  cp_sched_state_t      state_q, state_d;
  logic [CP_ADDR_W-1:0] ptr_q, ptr_d;
  logic [CP_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CP_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [CP_DATA_W-1:0] ram_din_q, ram_din_d;
  logic [CP_DATA_W-1:0] rd_data_q, rd_data_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 ram_we_q, ram_we_d;

  logic                 win;
  logic [CP_ADDR_W-1:0] eff_addr;
  logic                 full_now;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  cp_wr_entry_t         push_entry, head_entry;

  assign win        = HBL | VBL | FORCE;
  assign eff_addr   = SET_ADDR ? ADDR_IN : ptr_q;
  assign full_now   = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_push  = WR_REQ && !full_now;
  assign push_entry = '{addr: eff_addr, data: DATA_IN};

  cp_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .resn_i  (RESn),
    .ce_i    (CE),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (push_entry),
    .dout_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (!RESn) begin
      state_q <= ST_IDLE;
    end else if (CE) begin
      state_q <= state_d;
    end
  end

  // Pending writes always win over a pending read, which keeps reads behind earlier writes
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (win && !fifo_empty) begin
          state_d  = ST_WRITE;
          fifo_pop = 1'b1;
        end else if (win && busy_q) begin
          state_d = ST_RD_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Port registers are loaded from the state being entered so they line up with that state's period
  always_comb begin
    ptr_d      = ptr_q;
    rd_addr_d  = rd_addr_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    if (WR_REQ) begin
      ptr_d = eff_addr + CP_ADDR_W'(1);
    end else if (SET_ADDR) begin
      ptr_d = ADDR_IN;
    end
    if (WR_REQ && full_now) ovf_d = 1'b1;
    if (RD_REQ && !busy_q) begin
      rd_addr_d = eff_addr;
      busy_d    = 1'b1;
    end

    case (state_d)
      ST_WRITE: begin
        ram_we_d   = 1'b1;
        ram_addr_d = head_entry.addr;
        ram_din_d  = head_entry.data;
      end
      ST_RD_ISSUE: ram_addr_d = rd_addr_q;
      ST_RD_WAIT: begin
        rd_valid_d = 1'b1;
        rd_data_d  = RAM_Q;
        busy_d     = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESn) begin
      ptr_q      <= '0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (CE) begin
      ptr_q      <= ptr_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign PTR      = ptr_q;
  assign FULL     = fifo_full;
  assign BUSY     = busy_q;
  assign OVF      = ovf_q;
  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
  assign RAM_ADDR = ram_addr_q;
  assign RAM_DIN  = ram_din_q;
  assign RAM_WE   = ram_we_q;

endmodule

// File: tb/tb_huc6261_cp_sched.sv
// tb/tb_huc6261_cp_sched.sv - directed self-checking bench for the palette-port scheduler
module tb_huc6261_cp_sched;

  logic        CLK;
  logic        RESn;
  logic        CE;
  logic        SET_ADDR;
  logic [8:0]  ADDR_IN;
  logic        WR_REQ;
  logic [15:0] DATA_IN;
  logic        RD_REQ;
  logic        HBL, VBL, FORCE;
  logic [8:0]  PTR;
  logic        FULL, BUSY, OVF;
  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic [8:0]  RAM_ADDR;
  logic [15:0] RAM_DIN;
  logic        RAM_WE;
  logic [15:0] RAM_Q;

  logic [15:0] mem [512];
  logic [24:0] we_log [$];
  int          rv_cnt;
  int          n_checks;
  int          n_pass;

  huc6261_cp_sched #(
    .FIFO_DEPTH (4),
    .CP_ADDR_W  (9),
    .CP_DATA_W  (16)
  ) dut (
    .CLK      (CLK),
    .RESn     (RESn),
    .CE       (CE),
    .SET_ADDR (SET_ADDR),
    .ADDR_IN  (ADDR_IN),
    .WR_REQ   (WR_REQ),
    .DATA_IN  (DATA_IN),
    .RD_REQ   (RD_REQ),
    .HBL      (HBL),
    .VBL      (VBL),
    .FORCE    (FORCE),
    .PTR      (PTR),
    .FULL     (FULL),
    .BUSY     (BUSY),
    .OVF      (OVF),
    .RD_DATA  (RD_DATA),
    .RD_VALID (RD_VALID),
    .RAM_ADDR (RAM_ADDR),
    .RAM_DIN  (RAM_DIN),
    .RAM_WE   (RAM_WE),
    .RAM_Q    (RAM_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Palette RAM: read data for the address held during a period is ready by its closing edge
  initial for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
  always @(posedge CLK) if (RAM_WE) mem[RAM_ADDR] <= RAM_DIN;
  assign RAM_Q = mem[RAM_ADDR];

  always @(posedge CLK) begin
    if (CE && RAM_WE) we_log.push_back({RAM_ADDR, RAM_DIN});
    if (CE && RD_VALID) rv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rv_cnt   = 0;
    RESn = 1'b0; CE = 1'b1; SET_ADDR = 1'b0; ADDR_IN = '0; WR_REQ = 1'b0;
    DATA_IN = '0; RD_REQ = 1'b0; HBL = 1'b0; VBL = 1'b0; FORCE = 1'b0;
    step(); step();
    RESn = 1'b1;
    chk("rst_ptr", PTR, 0);
    chk("rst_full", FULL, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_rd_valid", RD_VALID, 0);
    chk("rst_rd_data", RD_DATA, 0);
    chk("rst_ram_we", RAM_WE, 0);
    chk("rst_ram_addr", RAM_ADDR, 0);
    chk("rst_ram_din", RAM_DIN, 0);

    // back-to-back writes across the pointer wrap
    HBL = 1'b1; SET_ADDR = 1'b1; ADDR_IN = 9'h1FE; step();
    SET_ADDR = 1'b0; WR_REQ = 1'b1; DATA_IN = 16'h1111; step();
    DATA_IN = 16'h2222; step();
    chk("b2b_we0", RAM_WE, 1);
    chk("b2b_addr0", RAM_ADDR, 9'h1FE);
    chk("b2b_din0", RAM_DIN, 16'h1111);
    DATA_IN = 16'h3333; step();
    chk("b2b_addr1", RAM_ADDR, 9'h1FF);
    chk("b2b_din1", RAM_DIN, 16'h2222);
    WR_REQ = 1'b0; step();
    chk("b2b_we2", RAM_WE, 1);
    chk("b2b_addr2", RAM_ADDR, 9'h000);
    chk("b2b_din2", RAM_DIN, 16'h3333);
    chk("b2b_ptr", PTR, 9'h001);
    step();
    chk("b2b_we_off", RAM_WE, 0);
    HBL = 1'b0; step();

    // deferred commit with overflow
    we_log.delete();
    SET_ADDR = 1'b1; ADDR_IN = 9'h100; step();
    SET_ADDR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      WR_REQ = 1'b1; DATA_IN = 16'hA000 + 16'(i); step();
      if (i == 3) begin
        chk("defer_full4", FULL, 1);
        chk("defer_ovf4", OVF, 0);
      end
    end
    WR_REQ = 1'b0;
    chk("defer_ovf", OVF, 1);
    chk("defer_ptr", PTR, 9'h105);
    chk("defer_no_we", we_log.size(), 0);
    HBL = 1'b1; step();
    chk("defer_full_clr", FULL, 0);
    chk("defer_we", RAM_WE, 1);
    chk("defer_first", {RAM_ADDR, RAM_DIN}, {9'h100, 16'hA000});
    step(); step(); step(); step();
    HBL = 1'b0;
    chk("defer_cnt", we_log.size(), 4);
    chk("defer_last", we_log[3], {9'h103, 16'hA003});

    // read ordered behind an earlier buffered write
    we_log.delete();
    SET_ADDR = 1'b1; ADDR_IN = 9'h010; step();
    SET_ADDR = 1'b0; WR_REQ = 1'b1; DATA_IN = 16'hABCD; step();
    WR_REQ = 1'b0; SET_ADDR = 1'b1; ADDR_IN = 9'h010; RD_REQ = 1'b1; step();
    SET_ADDR = 1'b0; RD_REQ = 1'b0;
    step(); step();
    chk("raw_busy", BUSY, 1);
    chk("raw_no_we", we_log.size(), 0);
    VBL = 1'b1; step();
    chk("raw_write_first", {RAM_WE, RAM_ADDR, RAM_DIN}, {1'b1, 9'h010, 16'hABCD});
    step();
    chk("raw_issue", {RAM_WE, RAM_ADDR, BUSY, RD_VALID}, {1'b0, 9'h010, 1'b1, 1'b0});
    step();
    chk("raw_valid", RD_VALID, 1);
    chk("raw_data", RD_DATA, 16'hABCD);
    chk("raw_busy_clr", BUSY, 0);
    VBL = 1'b0; step();
    chk("raw_valid_pulse", RD_VALID, 0);

    // window closes right after the read is issued
    we_log.delete();
    SET_ADDR = 1'b1; ADDR_IN = 9'h100; RD_REQ = 1'b1; step();
    SET_ADDR = 1'b0; RD_REQ = 1'b0;
    HBL = 1'b1; step();
    HBL = 1'b0; WR_REQ = 1'b1; DATA_IN = 16'h7777;
    chk("close_issue", {RAM_WE, RAM_ADDR}, {1'b0, 9'h100});
    step();
    WR_REQ = 1'b0;
    chk("close_valid", RD_VALID, 1);
    chk("close_data", RD_DATA, 16'hA000);
    step(); step(); step();
    chk("close_held", we_log.size(), 0);
    chk("close_ptr", PTR, 9'h101);
    FORCE = 1'b1; step();
    chk("close_force_we", {RAM_WE, RAM_ADDR, RAM_DIN}, {1'b1, 9'h100, 16'h7777});
    FORCE = 1'b0; step();
    chk("close_we_off", RAM_WE, 0);

    // SET_ADDR with WR_REQ, and a second read while busy
    HBL = 1'b1; SET_ADDR = 1'b1; ADDR_IN = 9'h080; WR_REQ = 1'b1; DATA_IN = 16'h5A5A; step();
    SET_ADDR = 1'b0; WR_REQ = 1'b0;
    chk("sim_ptr", PTR, 9'h081);
    step();
    chk("sim_write", {RAM_WE, RAM_ADDR, RAM_DIN}, {1'b1, 9'h080, 16'h5A5A});
    HBL = 1'b0; SET_ADDR = 1'b1; ADDR_IN = 9'h080; RD_REQ = 1'b1; step();
    ADDR_IN = 9'h1FE; step();
    SET_ADDR = 1'b0; RD_REQ = 1'b0;
    chk("sim_busy", BUSY, 1);
    rv_cnt = 0;
    HBL = 1'b1; step(); step(); step(); step();
    HBL = 1'b0;
    chk("sim_single_valid", rv_cnt, 1);
    chk("sim_rd_data", RD_DATA, 16'h5A5A);

    // CE low freezes all state
    CE = 1'b0; SET_ADDR = 1'b1; ADDR_IN = 9'h055; WR_REQ = 1'b1; DATA_IN = 16'hFFFF;
    step(); step();
    SET_ADDR = 1'b0; WR_REQ = 1'b0; CE = 1'b1;
    chk("ce_freeze_ptr", PTR, 9'h1FE);

    // reset with queued writes and a pending read
    rv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      WR_REQ = 1'b1; DATA_IN = 16'hB000 + 16'(i); step();
    end
    WR_REQ = 1'b0; RD_REQ = 1'b1; step();
    RD_REQ = 1'b0;
    chk("rst2_busy_before", BUSY, 1);
    RESn = 1'b0; HBL = 1'b1; step();
    we_log.delete();
    chk("rst2_state", {PTR, BUSY, OVF, FULL, RAM_WE, RD_VALID}, 0);
    chk("rst2_ram", {RAM_ADDR, RAM_DIN}, 0);
    chk("rst2_rd_data", RD_DATA, 0);
    RESn = 1'b1; step(); step(); step(); step();
    HBL = 1'b0;
    chk("rst2_no_we", we_log.size(), 0);
    chk("rst2_no_read", rv_cnt, 0);
    chk("rst2_busy", BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/huc6261_cp_sched.md
# huc6261_cp_sched

Palette-RAM access scheduler for the HuC6261 colour-palette RAM port A. It sits between the CPU register interface and the palette RAM. It buffers CPU palette writes in a small FIFO, keeps the auto-incrementing palette pointer, and commits writes and performs reads only inside blanking windows (or whenever the display is forced off). This keeps CPU traffic from colliding with active-display palette lookups. Reads are ordered after all earlier buffered writes.

## Interface
Parameters:
- FIFO_DEPTH, 4, write-buffer entries; power of two, 2..16
- CP_ADDR_W, 9, palette address width
- CP_DATA_W, 16, palette word width

Ports:
- CLK  in  1  system clock
- RESn  in  1  reset; one clock, synchronous, active-low
- CE  in  1  clock enable; all state advances only on CLK edges with CE=1
- SET_ADDR  in  1  one-CE pulse: load pointer from ADDR_IN
- ADDR_IN  in  CP_ADDR_W  new pointer value
- WR_REQ  in  1  one-CE pulse: queue DATA_IN at pointer, then pointer+1
- DATA_IN  in  CP_DATA_W  write data
- RD_REQ  in  1  one-CE pulse: read palette word at pointer (pointer unchanged)
- HBL, VBL  in  1  blanking flags from the video timing
- FORCE  in  1  display disabled; the access window is always open
- PTR  out  CP_ADDR_W  current pointer
- FULL  out  1  FIFO full
- BUSY  out  1  read pending
- OVF  out  1  sticky: a write was dropped
- RD_DATA  out  CP_DATA_W  last read result
- RD_VALID  out  1  one-CE pulse with fresh RD_DATA
- RAM_ADDR  out  CP_ADDR_W  palette port-A address
- RAM_DIN  out  CP_DATA_W  palette port-A write data
- RAM_WE  out  1  palette port-A write enable
- RAM_Q  in  CP_DATA_W  palette port-A read data; 1 CLK latency

## Operation
- Window: WIN = HBL | VBL | FORCE, sampled on the deciding CE edge.
- Pointer: CP_ADDR_W-bit and wraps (511+1 = 0).
  - SET_ADDR with WR_REQ in the same cycle: the write uses ADDR_IN, and PTR becomes ADDR_IN+1.
  - RD_REQ in the same cycle as SET_ADDR reads ADDR_IN.
- Queuing: WR_REQ pushes {address, data}.
  - If FULL, the entry is dropped, PTR still increments, and OVF is set.
  - A push and a pop on the same edge are both honoured.
- RD_REQ while BUSY is ignored. Otherwise it latches the read address and sets BUSY.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT.
  - IDLE: if WIN and FIFO not empty, pop and go to WRITE. Else if WIN, FIFO empty and BUSY, go to RD_ISSUE. Writes always beat reads, which gives read-after-write ordering.
  - WRITE: RAM_ADDR/RAM_DIN = popped entry and RAM_WE=1 for this one CE period. Repeated CLK writes of the same word are harmless. Then: another write if WIN and FIFO not empty; a read issue if WIN, FIFO empty and BUSY; otherwise IDLE.
  - RD_ISSUE: RAM_ADDR = read address, RAM_WE=0. Go to RD_WAIT unconditionally; a window close does not abort the read.
  - RD_WAIT: RD_DATA <= RAM_Q, RD_VALID=1, BUSY cleared, then IDLE.
- A window closing never aborts an operation already in a state. It only blocks new decisions.

## Timing
- Reset values: PTR=0, FULL=0, BUSY=0, OVF=0, RD_DATA=0, RD_VALID=0, RAM_ADDR=0, RAM_DIN=0, RAM_WE=0; FIFO empty; state IDLE.
- Reset mid-operation flushes the FIFO and discards any pending read. No RAM_WE is asserted in the period after the reset edge.
- All outputs are registered and change only on CE edges.
- Write latency (window open, FIFO empty): WR_REQ at CE edge N → RAM_WE high during period N+1 → N+2.
- Sustained write throughput: one word per CE period while WIN=1.
- Read latency (window open, FIFO empty): RD_REQ at edge N → RAM_ADDR valid during period N+1 → RD_VALID and RD_DATA during period N+2 → N+3, with BUSY low from edge N+2.
- FULL asserts on the edge that makes the count equal FIFO_DEPTH and clears on the first pop.

## Structure
- Shared package huc6261_pkg holds: CP_ADDR_W and CP_DATA_W constants, the FSM state enum cp_sched_state_t, and the FIFO entry struct cp_wr_entry_t {addr, data}.
- One sub-module, cp_wr_fifo: a synchronous FIFO with push, pop, full, empty and count, plus a CE input.
- The FSM, pointer, read latch and RAM port registers live in huc6261_cp_sched.

## Test plan
- Back-to-back writes in blanking: SET_ADDR 0x1FE, WR_REQ 0x1111, 0x2222, 0x3333 with WIN=1 → RAM writes 0x1FE=0x1111, 0x1FF=0x2222, 0x000=0x3333 on consecutive CE periods; PTR=0x001.
- Deferred commit: VBL=HBL=FORCE=0, five WR_REQ at FIFO_DEPTH=4 → FULL after the 4th, OVF=1, no RAM_WE. Then raise HBL → exactly 4 RAM_WE periods, FULL clears after the first.
- Read ordering: WIN=0, SET_ADDR 0x010, WR_REQ 0xABCD, SET_ADDR 0x010, RD_REQ → BUSY=1, no RAM activity. Raise VBL → the write commits first, then RD_VALID with RD_DATA=0xABCD.
- Window closes mid-read: HBL drops on the edge that enters RD_ISSUE → the read still completes 1 CE later with correct data. The next queued write waits for the next window.
- Simultaneous events: SET_ADDR 0x080 with WR_REQ 0x5A5A → write lands at 0x080, PTR=0x081. RD_REQ while BUSY → ignored, a single RD_VALID.
- Reset mid-burst: RESn=0 with 3 queued writes and BUSY=1 → no further RAM_WE, and all outputs return to their reset values on the next edge.
